// File: rtl/ram_read_arbiter_if.sv
// ram_read_arbiter_if: channel-side and shared-bus signals of the RAM read arbiter
interface ram_read_arbiter_if #(
    parameter int CHANNELS     = 3,
    parameter int CHAN_WID     = 2,
    parameter int RAM_WID      = 32,
    parameter int RAM_WORD_WID = 16
);
    logic [CHANNELS*RAM_WID-1:0]      ram_dma_addr;
    logic [CHANNELS-1:0]              ram_read;
    logic [CHANNELS*RAM_WORD_WID-1:0] ram_word;
    logic [CHANNELS-1:0]              ram_valid;
    logic [RAM_WID-1:0]               bus_addr;
    logic                             bus_read;
    logic [RAM_WORD_WID-1:0]          bus_data;
    logic                             bus_ack;
    logic [CHAN_WID-1:0]              grant;
    logic [CHANNELS-1:0]              timeout_err;
    logic                             err_clear;

    modport slave (
        input  ram_dma_addr, ram_read, bus_data, bus_ack, err_clear,
        output ram_word, ram_valid, bus_addr, bus_read, grant, timeout_err
    );

    modport master (
        output ram_dma_addr, ram_read, bus_data, bus_ack, err_clear,
        input  ram_word, ram_valid, bus_addr, bus_read, grant, timeout_err
    );
endinterface

// File: rtl/ram_read_arbiter.sv
// ram_read_arbiter: round-robin sharing of one RAM read port among several channels
module ram_read_arbiter #(
    parameter int CHANNELS     = 3,
    parameter int CHAN_WID     = 2,
    parameter int RAM_WID      = 32,
    parameter int RAM_WORD_WID = 16,
    parameter int TIMEOUT      = 255,
    parameter int TIMEOUT_WID  = 8
) (
    input logic              clk,
    input logic              rst,
    ram_read_arbiter_if.slave io
);
    typedef enum logic [1:0] {IDLE, BUS_WAIT, HOLD_VALID} state_t;

    state_t                           state, state_n;
    logic [CHAN_WID-1:0]              grant, sel, rr_idx;
    logic [RAM_WID-1:0]               bus_addr;
    logic [CHANNELS*RAM_WORD_WID-1:0] ram_word;
    logic [CHANNELS-1:0]              timeout_err, grant_mask, ram_valid;
    logic [TIMEOUT_WID-1:0]           wait_cnt;
    logic                             any_req, granted_req, timed_out, accept, bus_read;

    assign any_req     = |io.ram_read;
    assign granted_req = io.ram_read[grant];
    assign grant_mask  = CHANNELS'(1) << grant;
    assign timed_out   = state == BUS_WAIT && !io.bus_ack && wait_cnt == TIMEOUT_WID'(TIMEOUT - 1);
    assign accept      = state == BUS_WAIT && io.bus_ack && granted_req;

    // Round-robin pick: scanning from farthest to nearest leaves the channel right after grant as winner
    always_comb begin
        sel    = grant;
        rr_idx = grant;
        for (int i = CHANNELS; i >= 1; i--) begin
            rr_idx = CHAN_WID'((int'(grant) + i) % CHANNELS);
            if (io.ram_read[rr_idx]) sel = rr_idx;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state; a withdrawn request still waits for the bus to answer before going idle
    always_comb begin
        state_n = state;
        case (state)
            IDLE:       state_n = any_req ? BUS_WAIT : IDLE;
            BUS_WAIT:   state_n = io.bus_ack ? (granted_req ? HOLD_VALID : IDLE) : (timed_out ? IDLE : BUS_WAIT);
            HOLD_VALID: state_n = granted_req ? HOLD_VALID : IDLE;
            default:    state_n = IDLE;
        endcase
    end

    // Strobes decoded from state so they can never outlive their state
    always_comb begin
        bus_read  = state == BUS_WAIT;
        ram_valid = state == HOLD_VALID ? grant_mask : '0;
    end

    // Datapath: grant/address latch, returned words, bus wait counter and sticky errors (set beats clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            grant       <= CHAN_WID'(CHANNELS - 1);
            bus_addr    <= '0;
            ram_word    <= '0;
            timeout_err <= '0;
            wait_cnt    <= '0;
        end else begin
            wait_cnt    <= state == BUS_WAIT ? wait_cnt + TIMEOUT_WID'(1) : '0;
            timeout_err <= (io.err_clear ? '0 : timeout_err) | (timed_out ? grant_mask : '0);
            if (state == IDLE && any_req) begin
                grant    <= sel;
                bus_addr <= io.ram_dma_addr[int'(sel)*RAM_WID +: RAM_WID];
            end
            if (accept) ram_word[int'(grant)*RAM_WORD_WID +: RAM_WORD_WID] <= io.bus_data;
        end
    end

    assign io.bus_read    = bus_read;
    assign io.bus_addr    = bus_addr;
    assign io.ram_valid   = ram_valid;
    assign io.ram_word    = ram_word;
    assign io.grant       = grant;
    assign io.timeout_err = timeout_err;
endmodule

// File: tb/tb_ram_read_arbiter.sv
// tb_ram_read_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_ram_read_arbiter;
    localparam int CH = 3, CW = 2, AW = 32, DW = 16, TO = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_read_arbiter_if #(.CHANNELS(CH), .CHAN_WID(CW), .RAM_WID(AW), .RAM_WORD_WID(DW)) io();

    ram_read_arbiter #(
        .CHANNELS(CH), .CHAN_WID(CW), .RAM_WID(AW), .RAM_WORD_WID(DW), .TIMEOUT(TO), .TIMEOUT_WID(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io(io)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]  exp_word [CH];
    logic [AW-1:0]  addr [CH];
    logic [CH-1:0]  req, exp_valid;
    int             hold [CH];
    int             served [CH];
    int             last_g, g, cur_g, wcnt, stall, n;
    logic           prev_br, vbad;
    logic [DW-1:0]  d;

    assign io.ram_read = req;

    // Pack per-channel addresses onto the flat bus
    always_comb begin
        io.ram_dma_addr = '0;
        for (int i = 0; i < CH; i++) io.ram_dma_addr[i*AW +: AW] = addr[i];
    end

    function automatic logic [CH*DW-1:0] pack_words();
        logic [CH*DW-1:0] r;
        r = '0;
        for (int i = 0; i < CH; i++) r[i*DW +: DW] = exp_word[i];
        return r;
    endfunction

    function automatic int rr(input int last, input logic [CH-1:0] m);
        for (int i = 1; i <= CH; i++) if (m[(last + i) % CH]) return (last + i) % CH;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) exp_word[i] = '0;
        exp_valid = '0;
        last_g = CH - 1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        io.bus_ack = 1'b0;
        io.err_clear = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_bus_read"}, io.bus_read, 0);
        chk({tag, "_bus_addr"}, io.bus_addr, 0);
        chk({tag, "_ram_valid"}, io.ram_valid, 0);
        chk({tag, "_ram_word"}, io.ram_word, 0);
        chk({tag, "_grant"}, io.grant, CH - 1);
        chk({tag, "_timeout_err"}, io.timeout_err, 0);
    endtask

    task automatic wait_bus_read(input string tag);
        int k;
        k = 0;
        while (!io.bus_read && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_bus_read_seen"}, io.bus_read, 1);
    endtask

    task automatic ack(input logic [DW-1:0] v);
        io.bus_ack = 1'b1;
        io.bus_data = v;
        tick();
        io.bus_ack = 1'b0;
    endtask

    task automatic do_timeout(input int ch, input bit clear_last, output int cnt, output logic bad);
        req[ch] = 1'b1;
        addr[ch] = $urandom;
        tick();
        cnt = 0;
        bad = 1'b0;
        while (io.bus_read && cnt < TO + 10) begin
            cnt++;
            if (io.ram_valid != '0) bad = 1'b1;
            if (clear_last && cnt == TO) io.err_clear = 1'b1;
            tick();
            io.err_clear = 1'b0;
        end
        req[ch] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        io.bus_data = '0;
        for (int i = 0; i < CH; i++) addr[i] = '0;
        do_reset();
        check_reset_state("reset");

        // single request on channel 1, answered on the third bus cycle
        addr[1] = 32'h100;
        req[1] = 1'b1;
        tick();
        chk("single_bus_read", io.bus_read, 1);
        chk("single_bus_addr", io.bus_addr, 32'h100);
        chk("single_grant", io.grant, 1);
        tick();
        tick();
        chk("single_no_early_valid", io.ram_valid, 0);
        ack(16'hBEEF);
        exp_word[1] = 16'hBEEF;
        chk("single_valid", io.ram_valid, 3'b010);
        chk("single_word", io.ram_word, pack_words());
        chk("single_bus_read_low", io.bus_read, 0);
        repeat (4) tick();
        chk("single_valid_held", io.ram_valid, 3'b010);
        req[1] = 1'b0;
        tick();
        chk("single_release", io.ram_valid, 0);

        // all three channels contend continuously after reset
        do_reset();
        for (int i = 0; i < CH; i++) addr[i] = 32'h10 * (i + 1);
        req = '1;
        for (int k = 0; k < 4; k++) begin
            wait_bus_read("rr");
            chk("rr_grant", io.grant, k % CH);
            chk("rr_addr", io.bus_addr, addr[k % CH]);
            d = DW'($urandom);
            ack(d);
            exp_word[k % CH] = d;
            chk("rr_valid", io.ram_valid, 1 << (k % CH));
            chk("rr_words", io.ram_word, pack_words());
            req[k % CH] = 1'b0;
            tick();
            chk("rr_release", io.ram_valid, 0);
            req[k % CH] = 1'b1;
        end

        // bus never answers: timeout, then timeout coinciding with err_clear
        do_reset();
        do_timeout(2, 1'b0, n, vbad);
        chk("timeout_cycles", n, TO);
        chk("timeout_no_valid", vbad, 0);
        tick();
        chk("timeout_err_set", io.timeout_err, 3'b100);
        chk("timeout_valid_low", io.ram_valid, 0);
        do_timeout(0, 1'b1, n, vbad);
        chk("timeout2_cycles", n, TO);
        chk("timeout2_grant", io.grant, 0);
        chk("timeout_set_wins", io.timeout_err, 3'b001);
        io.err_clear = 1'b1;
        tick();
        io.err_clear = 1'b0;
        chk("timeout_cleared", io.timeout_err, 0);

        // channel 0 completes a read, then withdraws a second one mid-wait
        addr[0] = 32'hA0;
        req[0] = 1'b1;
        wait_bus_read("pre_withdraw");
        ack(16'h5A5A);
        exp_word[0] = 16'h5A5A;
        chk("pre_withdraw_valid", io.ram_valid, 3'b001);
        req[0] = 1'b0;
        tick();
        addr[0] = 32'hB0;
        req[0] = 1'b1;
        wait_bus_read("withdraw");
        chk("withdraw_addr", io.bus_addr, 32'hB0);
        req[0] = 1'b0;
        tick();
        chk("withdraw_still_waiting", io.bus_read, 1);
        ack(16'h1234);
        chk("withdraw_bus_read_low", io.bus_read, 0);
        chk("withdraw_no_valid", io.ram_valid, 0);
        chk("withdraw_word_kept", io.ram_word, pack_words());
        ack(16'hDEAD);
        chk("idle_ack_ignored", io.ram_word, pack_words());
        chk("idle_ack_no_valid", io.ram_valid, 0);

        // reset while the bus is busy, late acknowledge must be ignored
        addr[1] = 32'h200;
        req[1] = 1'b1;
        wait_bus_read("rst_mid");
        tick();
        rst = 1'b1;
        req[1] = 1'b0;
        tick();
        rst = 1'b0;
        ack(16'hFFFF);
        model_reset();
        check_reset_state("rst_mid");
        tick();
        chk("rst_mid_no_valid", io.ram_valid, 0);

        // randomized traffic against the transaction-level model
        do_reset();
        for (int i = 0; i < CH; i++) begin
            hold[i] = 0;
            served[i] = 0;
        end
        prev_br = 1'b0;
        cur_g = 0;
        wcnt = 0;
        stall = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("rnd_valid", io.ram_valid, exp_valid);
            chk("rnd_words", io.ram_word, pack_words());
            chk("rnd_onehot", $countones(io.ram_valid) <= 1, 1);
            if (io.bus_read && !prev_br) begin
                g = rr(last_g, req);
                chk("rnd_req_present", g >= 0, 1);
                if (g < 0) g = 0;
                chk("rnd_grant", io.grant, g);
                chk("rnd_addr", io.bus_addr, addr[g]);
                last_g = g;
                cur_g = g;
                wcnt = $urandom_range(0, 4);
                served[g]++;
            end
            stall = (!io.bus_read && io.ram_valid == '0 && req != '0) ? stall + 1 : 0;
            chk("rnd_no_stall", stall <= 2, 1);
            prev_br = io.bus_read;
            io.bus_ack = 1'b0;
            for (int c = 0; c < CH; c++) begin
                if (exp_valid[c]) begin
                    hold[c]--;
                    if (hold[c] == 0) begin
                        req[c] = 1'b0;
                        exp_valid[c] = 1'b0;
                    end
                end else if (!req[c] && $urandom_range(0, 3) == 0) begin
                    req[c] = 1'b1;
                    addr[c] = $urandom;
                end
            end
            if (io.bus_read) begin
                if (wcnt == 0) begin
                    d = DW'($urandom);
                    io.bus_ack = 1'b1;
                    io.bus_data = d;
                    exp_word[cur_g] = d;
                    exp_valid[cur_g] = 1'b1;
                    hold[cur_g] = $urandom_range(1, 4);
                end else begin
                    wcnt--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                io.bus_ack = 1'b1;
                io.bus_data = DW'($urandom);
            end
            tick();
        end
        for (int c = 0; c < CH; c++) chk("rnd_served", served[c] > 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
